// File: rtl/nibbler_pkg.sv
// Shared widths, loader state encoding and default frame marker for the Nibbler
// program-memory loader.
package nibbler_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 8;

    localparam logic [DATA_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } loader_state_t;

endpackage

// File: rtl/nibbler_program_loader.sv
// Frame receiver that writes a host byte stream into Nibbler program memory and
// releases the CPU reset only after a checksum-verified load.
module nibbler_program_loader
    import nibbler_pkg::*;
#(
    parameter int unsigned       WRITE_CYCLES  = 1,
    parameter bit                HOLD_AT_RESET = 1'b1,
    parameter logic [DATA_W-1:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic              rxValid,
    input  logic [DATA_W-1:0] rxByte,
    output logic              rxReady,
    output logic              romWriteEnable,
    output logic [ADDR_W-1:0] romAddress,
    output logic [DATA_W-1:0] romData,
    output logic              cpuNotReset,
    output logic              loadDone,
    output logic              loadError
);

    // Out-of-range WRITE_CYCLES values are clamped into 1..15.
    localparam logic [3:0] HOLD_LAST = (WRITE_CYCLES < 2)  ? 4'd0  :
                                       (WRITE_CYCLES > 15) ? 4'd14 :
                                       4'(WRITE_CYCLES - 1);

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] len, len_next;
    logic [ADDR_W-1:0] addr_cnt, addr_cnt_next;
    logic [DATA_W-1:0] sum, sum_next;
    logic [3:0]        hold_cnt, hold_cnt_next;
    logic [ADDR_W-1:0] rom_address_next;
    logic [DATA_W-1:0] rom_data_next;
    logic              cpu_run_next;
    logic              done_next;
    logic              error_next;
    logic              accept;
    logic [ADDR_W-1:0] len_full;

    assign accept   = rxValid & rxReady;
    assign len_full = {len[11:8], rxByte};

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state          <= ST_IDLE;
            len            <= '0;
            addr_cnt       <= '0;
            sum            <= '0;
            hold_cnt       <= '0;
            rxReady        <= 1'b1;
            romWriteEnable <= 1'b0;
            romAddress     <= '0;
            romData        <= '0;
            cpuNotReset    <= ~HOLD_AT_RESET;
            loadDone       <= 1'b0;
            loadError      <= 1'b0;
        end else begin
            state          <= state_next;
            len            <= len_next;
            addr_cnt       <= addr_cnt_next;
            sum            <= sum_next;
            hold_cnt       <= hold_cnt_next;
            // Handshake and strobe are flops decoded from the next state.
            rxReady        <= (state_next != ST_WRITE);
            romWriteEnable <= (state_next == ST_WRITE);
            romAddress     <= rom_address_next;
            romData        <= rom_data_next;
            cpuNotReset    <= cpu_run_next;
            loadDone       <= done_next;
            loadError      <= error_next;
        end
    end

    always_comb begin
        state_next       = state;
        len_next         = len;
        addr_cnt_next    = addr_cnt;
        sum_next         = sum;
        hold_cnt_next    = hold_cnt;
        rom_address_next = romAddress;
        rom_data_next    = romData;
        cpu_run_next     = cpuNotReset;
        done_next        = loadDone;
        error_next       = loadError;

        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (accept && rxByte == SYNC_BYTE) begin
                    state_next   = ST_LEN_HI;
                    cpu_run_next = 1'b0;
                    done_next    = 1'b0;
                    error_next   = 1'b0;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if (rxByte[7:4] != 4'h0) begin
                        state_next   = ST_ERROR;
                        cpu_run_next = 1'b0;
                        error_next   = 1'b1;
                    end else begin
                        len_next   = {rxByte[3:0], len[7:0]};
                        state_next = ST_LEN_LO;
                    end
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_next      = len_full;
                    addr_cnt_next = '0;
                    sum_next      = '0;
                    state_next    = (len_full == '0) ? ST_CHECK : ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    rom_data_next    = rxByte;
                    rom_address_next = addr_cnt;
                    sum_next         = sum + rxByte;
                    hold_cnt_next    = '0;
                    state_next       = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (hold_cnt == HOLD_LAST) begin
                    addr_cnt_next = addr_cnt + 12'd1;
                    state_next    = (addr_cnt + 12'd1 == len) ? ST_CHECK : ST_DATA;
                end else begin
                    hold_cnt_next = hold_cnt + 4'd1;
                end
            end
            ST_CHECK: begin
                if (accept) begin
                    if (rxByte == sum) begin
                        state_next   = ST_DONE;
                        cpu_run_next = 1'b1;
                        done_next    = 1'b1;
                    end else begin
                        state_next   = ST_ERROR;
                        cpu_run_next = 1'b0;
                        error_next   = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_nibbler_program_loader.sv
// Directed bench for nibbler_program_loader: frame table on a single-cycle-write
// instance plus hand sequences for write hold, latency and mid-write reset.
module tb_nibbler_program_loader;

    logic clk = 1'b0;
    logic notReset = 1'b0;
    always #5 clk = ~clk;

    logic        v1 = 1'b0, v3 = 1'b0;
    logic [7:0]  b1 = '0,   b3 = '0;
    logic        rdy1, we1, cpu1, done1, err1;
    logic        rdy3, we3, cpu3, done3, err3;
    logic [11:0] a1, a3;
    logic [7:0]  d1, d3;

    nibbler_program_loader #(.WRITE_CYCLES(1), .HOLD_AT_RESET(1'b1), .SYNC_BYTE(8'hA5)) dut1 (
        .clk(clk), .notReset(notReset), .rxValid(v1), .rxByte(b1), .rxReady(rdy1),
        .romWriteEnable(we1), .romAddress(a1), .romData(d1), .cpuNotReset(cpu1),
        .loadDone(done1), .loadError(err1));

    nibbler_program_loader #(.WRITE_CYCLES(3), .HOLD_AT_RESET(1'b0), .SYNC_BYTE(8'hA5)) dut3 (
        .clk(clk), .notReset(notReset), .rxValid(v3), .rxByte(b3), .rxReady(rdy3),
        .romWriteEnable(we3), .romAddress(a3), .romData(d3), .cpuNotReset(cpu3),
        .loadDone(done3), .loadError(err3));

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitors, sampled on the falling edge.
    logic [19:0] q1[$];
    logic [19:0] q3[$];
    int unsigned runs3[$];
    int unsigned run3 = 0;
    int unsigned bad3 = 0;

    always @(negedge clk) begin
        if (we1) q1.push_back({a1, d1});
        if (we3) begin
            run3++;
            if (run3 == 1) q3.push_back({a3, d3});
            else if ({a3, d3} != q3[$]) bad3++;
            if (rdy3) bad3++;
        end else if (run3 != 0) begin
            runs3.push_back(run3);
            run3 = 0;
        end
    end

    // Called on a falling edge; returns on the falling edge after the accepting rise.
    task automatic send1(input logic [7:0] b);
        int unsigned guard = 0;
        v1 = 1'b1;
        b1 = b;
        while (!rdy1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("send1_timeout", guard, 0);
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic send3(input logic [7:0] b);
        int unsigned guard = 0;
        v3 = 1'b1;
        b3 = b;
        while (!rdy3 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("send3_timeout", guard, 0);
        @(negedge clk);
        v3 = 1'b0;
    endtask

    typedef struct {
        int unsigned nbytes;
        logic [63:0] bytes;   // byte i at [8*i +: 8]
        int unsigned nwrites;
        logic [79:0] writes;  // write i = {addr, data} at [20*i +: 20]
        logic        exp_done;
        logic        exp_err;
        logic        exp_cpu;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    function automatic vec_t mk(input int unsigned n, input logic [63:0] b, input int unsigned nw,
                                input logic [79:0] w, input logic dn, input logic er, input logic cp);
        vec_t r;
        r.nbytes = n; r.bytes = b; r.nwrites = nw; r.writes = w;
        r.exp_done = dn; r.exp_err = er; r.exp_cpu = cp;
        return r;
    endfunction

    logic [19:0] got;

    initial begin
        // A5 00 03 11 22 33 66: good 3-byte load
        vecs[0] = mk(7, 64'h00_66_33_22_11_03_00_A5, 3,
                     {20'h0, 20'h002_33, 20'h001_22, 20'h000_11}, 1, 0, 1);
        // A5 00 02 10 20 31: bad checksum (sum 30)
        vecs[1] = mk(6, 64'h00_00_31_20_10_02_00_A5, 2,
                     {20'h0, 20'h0, 20'h001_20, 20'h000_10}, 0, 1, 0);
        // A5 00 00 00: empty frame recovers from error
        vecs[2] = mk(4, 64'h00_00_00_00_00_00_00_A5, 0, 80'h0, 1, 0, 1);
        // A5 10: length high nibble set
        vecs[3] = mk(2, 64'h00_00_00_00_00_00_10_A5, 0, 80'h0, 0, 1, 0);
        // 5A 00 dropped in ERROR, then A5 00 01 FF FF
        vecs[4] = mk(7, 64'h00_FF_FF_01_00_A5_00_5A, 1,
                     {20'h0, 20'h0, 20'h0, 20'h000_FF}, 1, 0, 1);
        // A5 00 04 01 02 03 04 0A
        vecs[5] = mk(8, 64'h0A_04_03_02_01_04_00_A5, 4,
                     {20'h003_04, 20'h002_03, 20'h001_02, 20'h000_01}, 1, 0, 1);
        // A5 00 03 80 90 F0 00: checksum wraps mod 256 to 00
        vecs[6] = mk(7, 64'h00_00_F0_90_80_03_00_A5, 3,
                     {20'h0, 20'h002_F0, 20'h001_90, 20'h000_80}, 1, 0, 1);
        // A5 00 00 01: empty frame needs CHK 00
        vecs[7] = mk(4, 64'h00_00_00_00_01_00_00_A5, 0, 80'h0, 0, 1, 0);

        // Reset values
        @(negedge clk);
        check("rst_rdy", rdy1, 1);
        check("rst_we", we1, 0);
        check("rst_addr", a1, 0);
        check("rst_data", d1, 0);
        check("rst_cpu_hold1", cpu1, 0);
        check("rst_done", done1, 0);
        check("rst_err", err1, 0);
        check("rst_cpu_hold0", cpu3, 1);
        @(negedge clk);
        notReset = 1'b1;
        @(negedge clk);

        // Latency: strobe right after data accept, CPU released right after CHK accept
        send1(8'hA5); send1(8'h00); send1(8'h01);
        send1(8'h42);
        check("lat_we_on", we1, 1);
        check("lat_rdy_off", rdy1, 0);
        check("lat_addr", a1, 12'h000);
        check("lat_data", d1, 8'h42);
        @(negedge clk);
        check("lat_we_off", we1, 0);
        check("lat_cpu_before_chk", cpu1, 0);
        send1(8'h42);
        check("lat_cpu_after_chk", cpu1, 1);
        check("lat_done", done1, 1);

        // Frame table
        for (int v = 0; v < NV; v++) begin
            q1.delete();
            for (int i = 0; i < int'(vecs[v].nbytes); i++) send1(vecs[v].bytes[8*i +: 8]);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_nwrites", v), q1.size(), vecs[v].nwrites);
            for (int i = 0; i < int'(vecs[v].nwrites); i++) begin
                got = (i < q1.size()) ? q1[i] : 20'hFFFFF;
                check($sformatf("v%0d_write%0d", v, i), got, vecs[v].writes[20*i +: 20]);
            end
            check($sformatf("v%0d_done", v), done1, vecs[v].exp_done);
            check($sformatf("v%0d_err", v), err1, vecs[v].exp_err);
            check($sformatf("v%0d_cpu", v), cpu1, vecs[v].exp_cpu);
        end

        // Three-cycle write hold with rxValid kept high across bytes
        q3.delete(); runs3.delete(); bad3 = 0;
        send3(8'hA5);
        check("wc3_cpu_drop", cpu3, 0);
        send3(8'h00); send3(8'h03); send3(8'h11); send3(8'h22); send3(8'h33); send3(8'h66);
        repeat (2) @(negedge clk);
        check("wc3_nwrites", q3.size(), 3);
        check("wc3_nruns", runs3.size(), 3);
        for (int i = 0; i < 3; i++) begin
            got = (i < q3.size()) ? q3[i] : 20'hFFFFF;
            check($sformatf("wc3_write%0d", i), got, {12'(i), 8'(8'h11 * (i + 1))});
            check($sformatf("wc3_run%0d", i), (i < runs3.size()) ? runs3[i] : 0, 3);
        end
        check("wc3_hold_violations", bad3, 0);
        check("wc3_done", done3, 1);
        check("wc3_cpu", cpu3, 1);

        // Reset asserted while byte 1 of a 4-byte frame is being written
        send1(8'hA5); send1(8'h00); send1(8'h04); send1(8'h01); send1(8'h02);
        check("mr_we_before", we1, 1);
        #2 notReset = 1'b0;
        #1;
        check("mr_we_drop", we1, 0);
        check("mr_rdy", rdy1, 1);
        check("mr_addr", a1, 0);
        check("mr_data", d1, 0);
        check("mr_cpu", cpu1, 0);
        check("mr_cpu_hold0", cpu3, 1);
        @(negedge clk);
        notReset = 1'b1;
        @(negedge clk);
        q1.delete();
        send1(8'hA5); send1(8'h00); send1(8'h04);
        send1(8'h0A); send1(8'h0B); send1(8'h0C); send1(8'h0D); send1(8'h2E);
        repeat (2) @(negedge clk);
        check("mr_nwrites", q1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            got = (i < q1.size()) ? q1[i] : 20'hFFFFF;
            check($sformatf("mr_write%0d", i), got, {12'(i), 8'(8'h0A + i)});
        end
        check("mr_done", done1, 1);
        check("mr_cpu_after", cpu1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
